// File: rtl/pb_event_pkg.sv
// Shared types and helpers for the push-button event decoder.
package pb_event_pkg;

  // Gesture-tracking states of the decoder FSM.
  typedef enum logic [2:0] {
    IDLE,
    HELD1,
    WAIT2,
    HELD2,
    LONG
  } pb_evt_state_t;

  // Largest of three values; sizes the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_event_decoder.sv
// Push-button gesture classifier: single click, double click, long press and
// optional auto-repeat while long-held, all as registered one-cycle pulses.
// Optional feature: define PB_EVENT_REPEAT_EN to enable auto-repeat in LONG.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int DCLICK_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_pressed_pulse,
  input  logic pb_released_pulse,
  input  logic pb_pressed_status,
  output logic click_pulse,
  output logic double_click_pulse,
  output logic long_press_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int TW = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES));

  localparam logic [TW-1:0] LONG_LAST   = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DCLICK_LAST = TW'(DCLICK_CYCLES - 1);
`ifdef PB_EVENT_REPEAT_EN
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
`endif

  pb_evt_state_t state;
  logic [TW-1:0] timer;
  logic          rel;

  // A dropped status also counts as a release, covering a lost release pulse.
  assign rel = pb_released_pulse | ~pb_pressed_status;

`ifndef PB_EVENT_REPEAT_EN
  assign repeat_pulse = 1'b0;
`endif

  // Gesture FSM with its shared timer and registered event outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge values of state and timer.
    if (rst) begin
      state              <= IDLE;
      timer              <= '0;
      busy               <= 1'b0;
      click_pulse        <= 1'b0;
      double_click_pulse <= 1'b0;
      long_press_pulse   <= 1'b0;
`ifdef PB_EVENT_REPEAT_EN
      repeat_pulse       <= 1'b0;
`endif
    end else begin
      click_pulse        <= 1'b0;
      double_click_pulse <= 1'b0;
      long_press_pulse   <= 1'b0;
`ifdef PB_EVENT_REPEAT_EN
      repeat_pulse       <= 1'b0;
`endif
      // Timer saturates instead of wrapping; transitions below clear it.
      if (timer != '1) timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (pb_pressed_pulse) begin
            state <= HELD1;
            busy  <= 1'b1;
            timer <= '0;
          end
        end
        HELD1: begin
          if (rel) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state            <= LONG;
            timer            <= '0;
            long_press_pulse <= 1'b1;
          end
        end
        WAIT2: begin
          if (pb_pressed_pulse) begin
            state <= HELD2;
            timer <= '0;
          end else if (timer == DCLICK_LAST) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timer       <= '0;
            click_pulse <= 1'b1;
          end
        end
        HELD2: begin
          if (rel) begin
            state              <= IDLE;
            busy               <= 1'b0;
            timer              <= '0;
            double_click_pulse <= 1'b1;
          end
        end
        LONG: begin
          if (rel) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end
`ifdef PB_EVENT_REPEAT_EN
          else if (timer == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            timer        <= '0;
          end
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_event_decoder.sv
// Directed bench for pb_event_decoder with LONG=20, DCLICK=8, REPEAT=5.
// Cycle k is the interval after the k-th rising edge following reset release;
// inputs for cycle c are sampled at the edge ending it, results seen in c+1.
module tb_pb_event_decoder;

  logic clk = 1'b0;
  logic rst;
  logic pb_pressed_pulse;
  logic pb_released_pulse;
  logic pb_pressed_status;
  logic click_pulse;
  logic double_click_pulse;
  logic long_press_pulse;
  logic repeat_pulse;
  logic busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pb_event_decoder #(
    .LONG_CYCLES  (20),
    .DCLICK_CYCLES(8),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pb_pressed_pulse  (pb_pressed_pulse),
    .pb_released_pulse (pb_released_pulse),
    .pb_pressed_status (pb_pressed_status),
    .click_pulse       (click_pulse),
    .double_click_pulse(double_click_pulse),
    .long_press_pulse  (long_press_pulse),
    .repeat_pulse      (repeat_pulse),
    .busy              (busy)
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst               = 1'b1;
    pb_pressed_pulse  = 1'b0;
    pb_released_pulse = 1'b0;
    pb_pressed_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // One directed gesture. -1 marks an unused slot. Busy is expected high for
  // b_on <= k < b_end; cycle skip_k (the IDLE-return cycle) is not checked.
  task automatic run(input string name,
                     input int p1, input int r1, input int p2, input int r2,
                     input int rst_c,
                     input int e_click, input int e_dbl, input int e_long,
                     input int e_rep1, input int e_rep2,
                     input int b_on, input int b_end, input int skip_k);
    logic [3:0] exp_p;
    logic       exp_b;
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      rst               = (c == rst_c);
      pb_pressed_pulse  = (c == p1) || (c == p2);
      pb_released_pulse = (c == r1) || (c == r2);
      pb_pressed_status = (c >= p1 && c < r1) || (p2 >= 0 && c >= p2 && c < r2);
      @(posedge clk);
      #1;
      exp_p[3] = ((c + 1) == e_click);
      exp_p[2] = ((c + 1) == e_dbl);
      exp_p[1] = ((c + 1) == e_long);
`ifdef PB_EVENT_REPEAT_EN
      exp_p[0] = ((c + 1) == e_rep1) || ((c + 1) == e_rep2);
`else
      exp_p[0] = 1'b0;
`endif
      exp_b = ((c + 1) >= b_on) && ((c + 1) < b_end);
      check($sformatf("%s pulses c%0d", name, c + 1),
            {1'b0, click_pulse, double_click_pulse, long_press_pulse, repeat_pulse},
            {1'b0, exp_p});
      if ((c + 1) != skip_k)
        check($sformatf("%s busy c%0d", name, c + 1), {4'b0, busy}, {4'b0, exp_b});
    end
  endtask

  initial begin
    // Reset state: every output low while rst is held.
    apply_reset();
    check("reset outputs",
          {click_pulse, double_click_pulse, long_press_pulse, repeat_pulse, busy},
          5'b00000);

    // 1: single click, click at R+DCLICK+1 = 23.
    run("s1_click", 10, 14, -1, -1, -1, 23, -1, -1, -1, -1, 11, 23, 23);
    // 2: double click, pulse at second release + 1 = 21.
    run("s2_dclick", 10, 13, 17, 20, -1, -1, 21, -1, -1, -1, 11, 21, 21);
    // 3: long press at 31; repeats at 36 and 41 when enabled; none at 46.
    run("s3_long", 10, 45, -1, -1, -1, -1, -1, 31, 36, 41, 11, 46, 46);
    // 4: release in the long-threshold cycle is a short press; click at 39.
    run("s4_edge", 10, 30, -1, -1, -1, 39, -1, -1, -1, -1, 11, 39, 39);
    // 5: second press in the last window cycle still makes a double click.
    run("s5_lastwin", 10, 14, 22, 25, -1, -1, 26, -1, -1, -1, 11, 26, 26);
    // 6: reset mid-gesture aborts it; no click at 23, idle from 19.
    run("s6_abort", 10, 14, -1, -1, 18, -1, -1, -1, -1, -1, 11, 19, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
